// File: rtl/id_stage_fwd.sv
// Mipu pipeline decode stage: operand fetch with EX/MEM forwarding,
// load-use bubble insertion, JUMP resolution in ID and branch flush.
// Optional bubble counter is compiled in when STALL_CNT_EN is defined.
module id_stage_fwd #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 state,
    input  logic [15:0]          id_ir,
    input  logic [NREG*DW-1:0]   gr_bus,
    input  logic                 fw_ex_en,
    input  logic [2:0]           fw_ex_addr,
    input  logic [DW-1:0]        fw_ex_data,
    input  logic                 fw_mem_en,
    input  logic [2:0]           fw_mem_addr,
    input  logic [DW-1:0]        fw_mem_data,
    input  logic                 flush,
    output logic                 stall,
    output logic [15:0]          ex_ir,
    output logic [DW-1:0]        reg_A,
    output logic [DW-1:0]        reg_B,
    output logic [DW-1:0]        smdr,
    output logic                 jp_en,
    output logic [AW-1:0]        jp_addr
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]          bubble_cnt
`endif
);

    // Opcode map shared with the rest of the Mipu pipeline
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;
    localparam logic       EXEC     = 1'b1;

    logic [15:0]   ex_ir_q,  ex_ir_d;
    logic [DW-1:0] reg_a_q,  reg_a_d;
    logic [DW-1:0] reg_b_q,  reg_b_d;
    logic [DW-1:0] smdr_q,   smdr_d;
    logic          jp_en_q,  jp_en_d;
    logic [AW-1:0] jp_addr_q, jp_addr_d;

    logic [4:0]    op;
    logic [2:0]    r1, r2, r3;
    logic          cls_a, cls_b, ralu, is_store, imm4, imm8, is_ldih, is_jump;
    logic          hazard;
    logic [DW-1:0] opnd_r1, opnd_r2, opnd_r3;

    // Forwarding mux: EX result beats MEM/WB result beats register file
    function automatic logic [DW-1:0] opnd(
        input logic [2:0]         r,
        input logic [NREG*DW-1:0] grs,
        input logic               ex_en,
        input logic [2:0]         ex_addr,
        input logic [DW-1:0]      ex_data,
        input logic               mem_en,
        input logic [2:0]         mem_addr,
        input logic [DW-1:0]      mem_data
    );
        logic [DW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (r == 3'(i)) v = grs[i*DW +: DW];
        end
        if (mem_en && (mem_addr == r)) v = mem_data;
        if (ex_en && (ex_addr == r))   v = ex_data;
        return v;
    endfunction

    assign op = id_ir[15:11];
    assign r1 = id_ir[10:8];
    assign r2 = id_ir[6:4];
    assign r3 = id_ir[2:0];

    assign opnd_r1 = opnd(r1, gr_bus, fw_ex_en, fw_ex_addr, fw_ex_data, fw_mem_en, fw_mem_addr, fw_mem_data);
    assign opnd_r2 = opnd(r2, gr_bus, fw_ex_en, fw_ex_addr, fw_ex_data, fw_mem_en, fw_mem_addr, fw_mem_data);
    assign opnd_r3 = opnd(r3, gr_bus, fw_ex_en, fw_ex_addr, fw_ex_data, fw_mem_en, fw_mem_addr, fw_mem_data);

    // Opcode classification: which source fields are read and how reg_B is formed
    always_comb begin
        cls_a    = 1'b0;
        cls_b    = 1'b0;
        ralu     = 1'b0;
        is_store = 1'b0;
        imm4     = 1'b0;
        imm8     = 1'b0;
        is_ldih  = 1'b0;
        is_jump  = 1'b0;
        case (op)
            OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC,
            OP_JMPR, OP_ADDI, OP_SUBI: begin
                cls_a = 1'b1;
                imm8  = 1'b1;
            end
            OP_LDIH: begin
                cls_a   = 1'b1;
                is_ldih = 1'b1;
            end
            OP_LOAD: begin
                cls_b = 1'b1;
                imm4  = 1'b1;
            end
            OP_STORE: begin
                cls_b    = 1'b1;
                imm4     = 1'b1;
                is_store = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SLA, OP_SRA: begin
                cls_b = 1'b1;
                imm4  = 1'b1;
            end
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
                cls_b = 1'b1;
                ralu  = 1'b1;
            end
            OP_JUMP: is_jump = 1'b1;
            default: ;
        endcase
    end

    // Load-use hazard: the load in EX writes a register this instruction reads
    always_comb begin
        hazard = 1'b0;
        if (ex_ir_q[15:11] == OP_LOAD) begin
            hazard = (cls_a    && (ex_ir_q[10:8] == r1)) ||
                     (cls_b    && (ex_ir_q[10:8] == r2)) ||
                     (ralu     && (ex_ir_q[10:8] == r3)) ||
                     (is_store && (ex_ir_q[10:8] == r1));
        end
    end

    assign stall = reset && (state == EXEC) && !flush && hazard;

    // Next-state decode: flush beats stall beats normal issue
    always_comb begin
        ex_ir_d   = ex_ir_q;
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        smdr_d    = smdr_q;
        jp_en_d   = jp_en_q;
        jp_addr_d = jp_addr_q;
        if (state == EXEC) begin
            ex_ir_d   = 16'h0000;
            jp_en_d   = 1'b0;
            jp_addr_d = '0;
            if (!flush && !hazard) begin
                if (is_jump) begin
                    jp_en_d   = 1'b1;
                    jp_addr_d = AW'(id_ir[7:0]);
                end else begin
                    ex_ir_d = id_ir;
                end
                if (cls_a) reg_a_d = opnd_r1;
                if (cls_b) reg_a_d = opnd_r2;
                if (imm4)    reg_b_d = DW'(id_ir[3:0]);
                if (imm8)    reg_b_d = DW'(id_ir[7:0]);
                if (is_ldih) reg_b_d = DW'({id_ir[7:0], 8'h00});
                if (ralu)    reg_b_d = opnd_r3;
                if (is_store) smdr_d = opnd_r1;
            end
        end
    end

    // Pipeline register toward EX
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_ir_q   <= 16'h0000;
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            smdr_q    <= '0;
            jp_en_q   <= 1'b0;
            jp_addr_q <= '0;
        end else begin
            ex_ir_q   <= ex_ir_d;
            reg_a_q   <= reg_a_d;
            reg_b_q   <= reg_b_d;
            smdr_q    <= smdr_d;
            jp_en_q   <= jp_en_d;
            jp_addr_q <= jp_addr_d;
        end
    end

    assign ex_ir   = ex_ir_q;
    assign reg_A   = reg_a_q;
    assign reg_B   = reg_b_q;
    assign smdr    = smdr_q;
    assign jp_en   = jp_en_q;
    assign jp_addr = jp_addr_q;

`ifdef STALL_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating count of cycles lost to load-use bubbles and flushes
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((state == EXEC) && (stall || flush) && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    // Bubble counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) bubble_cnt_q <= 16'h0000;
        else        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd at DW=32 with hand-computed expectations.
module tb_id_stage_fwd;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 8;

    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_JUMP  = 5'b11000;

    logic               clock = 1'b0;
    logic               reset;
    logic               state;
    logic [15:0]        id_ir;
    logic [NREG*DW-1:0] gr_bus;
    logic               fw_ex_en;
    logic [2:0]         fw_ex_addr;
    logic [DW-1:0]      fw_ex_data;
    logic               fw_mem_en;
    logic [2:0]         fw_mem_addr;
    logic [DW-1:0]      fw_mem_data;
    logic               flush;
    logic               stall;
    logic [15:0]        ex_ir;
    logic [DW-1:0]      reg_A, reg_B, smdr;
    logic               jp_en;
    logic [AW-1:0]      jp_addr;
`ifdef STALL_CNT_EN
    logic [15:0]        bubble_cnt;
`endif

    logic [DW-1:0] gr [NREG];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NREG; i++) gr_bus[i*DW +: DW] = gr[i];
    end

    id_stage_fwd #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clock(clock), .reset(reset), .state(state), .id_ir(id_ir), .gr_bus(gr_bus),
        .fw_ex_en(fw_ex_en), .fw_ex_addr(fw_ex_addr), .fw_ex_data(fw_ex_data),
        .fw_mem_en(fw_mem_en), .fw_mem_addr(fw_mem_addr), .fw_mem_data(fw_mem_data),
        .flush(flush), .stall(stall), .ex_ir(ex_ir), .reg_A(reg_A), .reg_B(reg_B),
        .smdr(smdr), .jp_en(jp_en), .jp_addr(jp_addr)
`ifdef STALL_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        return {op, a, 1'b0, b, 1'b0, c};
    endfunction

    function automatic logic [15:0] enc_m(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b, input logic [3:0] imm);
        return {op, a, 1'b0, b, imm};
    endfunction

    function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] a, input logic [7:0] imm);
        return {op, a, imm};
    endfunction

    initial begin
        for (int i = 0; i < NREG; i++) gr[i] = 32'h1000 + 32'(i);
        gr[2] = 32'd5;
        gr[3] = 32'd7;
        gr[5] = 32'h0000BEEF;
        reset = 1'b0; state = 1'b1; id_ir = 16'h0000; flush = 1'b0;
        fw_ex_en = 1'b0; fw_ex_addr = 3'd0; fw_ex_data = '0;
        fw_mem_en = 1'b0; fw_mem_addr = 3'd0; fw_mem_data = '0;

        // reset state
        #12;
        check("rst_ex_ir", 64'(ex_ir), 64'h0);
        check("rst_reg_A", 64'(reg_A), 64'h0);
        check("rst_reg_B", 64'(reg_B), 64'h0);
        check("rst_smdr", 64'(smdr), 64'h0);
        check("rst_jp_en", 64'(jp_en), 64'h0);
        check("rst_jp_addr", 64'(jp_addr), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        reset = 1'b1;

        // plain ADD r1,r2,r3
        id_ir = enc_r(OP_ADD, 3'd1, 3'd2, 3'd3);
        tick();
        check("add_ex_ir", 64'(ex_ir), 64'(enc_r(OP_ADD, 3'd1, 3'd2, 3'd3)));
        check("add_reg_A", 64'(reg_A), 64'd5);
        check("add_reg_B", 64'(reg_B), 64'd7);
        check("add_jp_en", 64'(jp_en), 64'h0);

        // EX forward beats MEM forward on the same register
        fw_ex_en = 1'b1; fw_ex_addr = 3'd2; fw_ex_data = 32'd9;
        fw_mem_en = 1'b1; fw_mem_addr = 3'd2; fw_mem_data = 32'd3;
        tick();
        check("fwd_ex_prio_A", 64'(reg_A), 64'd9);
        check("fwd_ex_prio_B", 64'(reg_B), 64'd7);

        // MEM forward alone on r3
        fw_ex_en = 1'b0; fw_mem_addr = 3'd3; fw_mem_data = 32'h33;
        tick();
        check("fwd_mem_A", 64'(reg_A), 64'd5);
        check("fwd_mem_B", 64'(reg_B), 64'h33);
        fw_mem_en = 1'b0;

        // load-use: LOAD r4 then ADD r1,r4,r3
        id_ir = enc_m(OP_LOAD, 3'd4, 3'd2, 4'h1);
        tick();
        check("ld_ex_ir", 64'(ex_ir), 64'(enc_m(OP_LOAD, 3'd4, 3'd2, 4'h1)));
        check("ld_reg_A", 64'(reg_A), 64'd5);
        check("ld_reg_B", 64'(reg_B), 64'd1);
        id_ir = enc_r(OP_ADD, 3'd1, 3'd4, 3'd3);
        #1;
        check("lu_stall_hi", 64'(stall), 64'h1);
        tick();
        check("lu_bubble_ex_ir", 64'(ex_ir), 64'h0);
        check("lu_hold_A", 64'(reg_A), 64'd5);
        check("lu_hold_B", 64'(reg_B), 64'd1);
        check("lu_stall_lo", 64'(stall), 64'h0);
        fw_ex_en = 1'b1; fw_ex_addr = 3'd4; fw_ex_data = 32'h44;
        tick();
        check("lu_issue_ex_ir", 64'(ex_ir), 64'(enc_r(OP_ADD, 3'd1, 3'd4, 3'd3)));
        check("lu_issue_A", 64'(reg_A), 64'h44);
        check("lu_issue_B", 64'(reg_B), 64'd7);
`ifdef STALL_CNT_EN
        check("cnt_after_stall", 64'(bubble_cnt), 64'd1);
`endif
        fw_ex_en = 1'b0;

        // JUMP then a non-JUMP clears the request
        id_ir = enc_i(OP_JUMP, 3'd0, 8'h3C);
        tick();
        check("jmp_en", 64'(jp_en), 64'h1);
        check("jmp_addr", 64'(jp_addr), 64'h3C);
        check("jmp_ex_ir", 64'(ex_ir), 64'h0);
        check("jmp_hold_A", 64'(reg_A), 64'h44);
        id_ir = enc_i(OP_ADDI, 3'd1, 8'h12);
        tick();
        check("jmp_clr_en", 64'(jp_en), 64'h0);
        check("jmp_clr_addr", 64'(jp_addr), 64'h0);
        check("addi_ex_ir", 64'(ex_ir), 64'(enc_i(OP_ADDI, 3'd1, 8'h12)));
        check("addi_A", 64'(reg_A), 64'h1001);
        check("addi_B", 64'(reg_B), 64'h12);

        // STORE r5,r2,4 killed by flush, then issued
        id_ir = enc_m(OP_STORE, 3'd5, 3'd2, 4'h4);
        flush = 1'b1;
        tick();
        check("fl_ex_ir", 64'(ex_ir), 64'h0);
        check("fl_smdr_hold", 64'(smdr), 64'h0);
        check("fl_A_hold", 64'(reg_A), 64'h1001);
        flush = 1'b0;
        tick();
        check("st_ex_ir", 64'(ex_ir), 64'(enc_m(OP_STORE, 3'd5, 3'd2, 4'h4)));
        check("st_smdr", 64'(smdr), 64'h0000BEEF);
        check("st_A", 64'(reg_A), 64'd5);
        check("st_B", 64'(reg_B), 64'd4);
`ifdef STALL_CNT_EN
        check("cnt_after_flush", 64'(bubble_cnt), 64'd2);
`endif

        // idle state holds everything and ignores flush
        state = 1'b0; flush = 1'b1;
        id_ir = enc_r(OP_ADD, 3'd1, 3'd2, 3'd3);
        tick();
        check("idle_ex_ir", 64'(ex_ir), 64'(enc_m(OP_STORE, 3'd5, 3'd2, 4'h4)));
        check("idle_B", 64'(reg_B), 64'd4);
        check("idle_stall", 64'(stall), 64'h0);
`ifdef STALL_CNT_EN
        check("cnt_idle", 64'(bubble_cnt), 64'd2);
`endif
        state = 1'b1; flush = 1'b0;

        // LDIH immediate lands in the upper byte of the low half
        id_ir = enc_i(OP_LDIH, 3'd1, 8'hAB);
        tick();
        check("ldih_B", 64'(reg_B), 64'h0000AB00);
        check("ldih_A", 64'(reg_A), 64'h1001);

        // flush suppresses a pending load-use stall
        id_ir = enc_m(OP_LOAD, 3'd6, 3'd2, 4'h0);
        tick();
        id_ir = enc_r(OP_SUB, 3'd1, 3'd6, 3'd3);
        #1;
        check("fs_stall_hi", 64'(stall), 64'h1);
        flush = 1'b1;
        #1;
        check("fs_stall_forced_lo", 64'(stall), 64'h0);
        tick();
        check("fs_ex_ir", 64'(ex_ir), 64'h0);
`ifdef STALL_CNT_EN
        check("cnt_flush_stall", 64'(bubble_cnt), 64'd3);
`endif
        flush = 1'b0;

        // reset asserted mid-stall (hazard on r3 field)
        id_ir = enc_m(OP_LOAD, 3'd6, 3'd2, 4'h0);
        tick();
        id_ir = enc_r(OP_SUB, 3'd1, 3'd2, 3'd6);
        #1;
        check("rs_stall_hi", 64'(stall), 64'h1);
        reset = 1'b0;
        #1;
        check("rs_stall", 64'(stall), 64'h0);
        check("rs_ex_ir", 64'(ex_ir), 64'h0);
        check("rs_reg_A", 64'(reg_A), 64'h0);
        check("rs_reg_B", 64'(reg_B), 64'h0);
        check("rs_smdr", 64'(smdr), 64'h0);
        check("rs_jp_en", 64'(jp_en), 64'h0);
`ifdef STALL_CNT_EN
        check("rs_cnt", 64'(bubble_cnt), 64'd0);
`endif
        #2;
        reset = 1'b1;
        tick();
        check("post_rs_ex_ir", 64'(ex_ir), 64'(enc_r(OP_SUB, 3'd1, 3'd2, 3'd6)));
        check("post_rs_A", 64'(reg_A), 64'd5);
        check("post_rs_B", 64'(reg_B), 64'h1006);
        check("post_rs_stall", 64'(stall), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
